ex_div: RTL and testbench
=========================

Name: ex_div

Overview:
- Multi-cycle RV32M divide unit in the EX stage.
- Consumes operands, destination register and write enable delivered by the ID/EX pipeline register.
- Computes DIV/DIVU/REM/REMU with a radix-2 restoring algorithm.
- Returns a one-cycle register-write strobe toward writeback, and holds the front of the pipeline via stall_req while busy.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
- sys_clk  input  1  clock, rising edge
- sys_rst_n  input  1  asynchronous active-low reset
- start  input  1  issue request; sampled only in IDLE
- funct  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- op1  input  XLEN  dividend
- op2  input  XLEN  divisor
- rd_addr  input  5  destination register
- rd_wen  input  1  destination write enable, captured with start
- flush  input  1  abort in-flight operation (branch/exception)
- busy  output  1  high in CALC and DONE
- stall_req  output  1  pipeline hold request
- result  output  XLEN  quotient or remainder, valid when rd_wen_o=1
- rd_addr_o  output  5  captured rd_addr
- rd_wen_o  output  1  one-cycle writeback strobe

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (sys_clk, sys_rst_n).
- Reset values: state=IDLE; busy=0; result=0; rd_addr_o=0; rd_wen_o=0; internal quotient/remainder/counter=0. Reset mid-operation discards the operation; no write is issued.
- States: IDLE, CALC, DONE.
- IDLE, start=1, flush=0:
  - capture funct, rd_addr, rd_wen;
  - convert operands to magnitudes for signed ops; record quotient sign (op1[31]^op2[31]) and remainder sign (op1[31]).
  - Special cases go directly to DONE with result preloaded:
    - op2==0: quotient all-ones, remainder=op1.
    - DIV/REM with op1=0x80000000 and op2=0xFFFFFFFF: quotient=0x80000000, remainder=0.
  - Otherwise go to CALC with counter=0.
- CALC:
  - One quotient bit per cycle: shift {rem,quot} left 1, trial-subtract divisor, keep if non-negative, set quot LSB.
  - After XLEN cycles (counter==XLEN-1), go to DONE.
- DONE:
  - result = quotient or remainder per funct, sign-corrected (two's-complement negate when the recorded sign is set and the op is signed).
  - rd_wen_o = captured rd_wen for exactly this cycle; then IDLE.
- Latency, start edge to rd_wen_o high: special cases 1 cycle; normal XLEN+1 = 33 cycles.
- Throughput: a new start is accepted the cycle after DONE, i.e. in IDLE. Back-to-back issue therefore gives 34-cycle spacing.
- rd_wen_o, rd_addr_o and result are registered. result holds its last value outside DONE; rd_wen_o is 0 outside DONE.
- stall_req = (state==IDLE & start & ~flush) | (state==CALC). stall_req is low in DONE so the pipeline advances with the writeback.
- start asserted while busy is ignored; no queueing.
- flush in CALC or DONE: next state IDLE, rd_wen_o forced 0 that cycle, no write. flush in IDLE with start: start ignored.
- Simultaneous flush and reset: reset dominates.
- rd_wen=0 with rd_addr=0 still runs full latency; rd_wen_o stays 0.

Optional Feature:
- Macro: EX_DIV_EARLY_OUT_EN.
- Defined: in IDLE, if the unsigned dividend magnitude < divisor magnitude (divisor nonzero), go directly to DONE with quotient=0 and remainder=dividend (sign-corrected). Latency is 1 cycle.
- Undefined: such operands take the normal 33-cycle path. Results are identical either way; only latency differs.

Test Plan:
- DIVU op1=100, op2=7, rd_addr=5, rd_wen=1 -> after 33 cycles rd_wen_o=1 for one cycle, result=14, rd_addr_o=5; stall_req high from the start cycle through CALC.
- REM op1=-100 (0xFFFFFF9C), op2=7 -> result=0xFFFFFFFE (-2); DIV on the same operands -> 0xFFFFFFF2 (-14).
- Divide by zero: DIVU 0x1234/0 -> 1 cycle, result=0xFFFFFFFF; REMU 0x1234/0 -> result=0x1234.
- Overflow: DIV 0x80000000/0xFFFFFFFF -> 1 cycle, result=0x80000000; REM on the same operands -> result=0.
- Flush at CALC cycle 10 of DIVU 50/3 -> no rd_wen_o pulse, busy=0 next cycle; a new DIVU 9/3 issued then completes with result=3. Assert reset at CALC cycle 20 -> all outputs 0 immediately.
- With EX_DIV_EARLY_OUT_EN: DIVU 3/10 -> rd_wen_o 1 cycle after start, result=0; REMU 3/10 -> result=3. Without the macro -> same values at 33 cycles.

Source files
------------

// File: rtl/ex_div.sv
// ----------------------------------------------------------------------------
// ex_div -- multi-cycle RV32M divide unit for the EX stage.
//
// Implements DIV / DIVU / REM / REMU with a radix-2 restoring divider that
// retires one quotient bit per cycle. Operands, destination register and
// write enable come from the ID/EX register. The result is returned as a
// one-cycle writeback strobe. The front of the pipeline is held through
// stall_req while the divider iterates.
//
// Optional feature (compile-time macro EX_DIV_EARLY_OUT_EN):
//   When defined, an operation whose dividend magnitude is smaller than its
//   non-zero divisor magnitude skips iteration and completes in one cycle.
//   Results are identical with or without the macro; only latency differs.
//
// Ports:
//   sys_clk    in   rising-edge clock
//   sys_rst_n  in   asynchronous active-low reset
//   start      in   issue request, sampled only in IDLE
//   funct      in   00 DIV, 01 DIVU, 10 REM, 11 REMU
//   op1        in   dividend
//   op2        in   divisor
//   rd_addr    in   destination register
//   rd_wen     in   destination write enable, captured with start
//   flush      in   abort the in-flight operation
//   busy       out  high while in CALC or DONE
//   stall_req  out  pipeline hold request
//   result     out  quotient or remainder, valid while rd_wen_o is high
//   rd_addr_o  out  captured destination register
//   rd_wen_o   out  one-cycle writeback strobe
// ----------------------------------------------------------------------------
module ex_div #(
    parameter int XLEN = 32
) (
    input  logic            sys_clk,
    input  logic            sys_rst_n,
    input  logic            start,
    input  logic [1:0]      funct,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic [4:0]      rd_addr,
    input  logic            rd_wen,
    input  logic            flush,
    output logic            busy,
    output logic            stall_req,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_addr_o,
    output logic            rd_wen_o
);

    localparam int CNT_W = $clog2(XLEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    // Captured operation context
    logic            sel_rem_q;   // 1: return remainder, 0: return quotient
    logic            neg_q_q;     // negate quotient at the end (signed ops only)
    logic            neg_r_q;     // negate remainder at the end (signed ops only)
    logic            rd_wen_cap_q;
    logic            rd_wen_q;

    // Divider datapath
    logic [XLEN-1:0]  rem_q;
    logic [XLEN-1:0]  quot_q;
    logic [XLEN-1:0]  dvsr_q;
    logic [CNT_W-1:0] cnt_q;

    // ------------------------------------------------------------------
    // Issue-side decode (operates on the raw inputs while in IDLE)
    // ------------------------------------------------------------------
    logic            accept;
    logic            is_signed;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic            div_zero;
    logic            overflow;
    logic            early_out;
    logic            special;
    logic [XLEN-1:0] special_res;

    assign accept    = (state == S_IDLE) & start & ~flush;
    assign is_signed = ~funct[0];
    assign mag_a     = (is_signed & op1[XLEN-1]) ? -op1 : op1;
    assign mag_b     = (is_signed & op2[XLEN-1]) ? -op2 : op2;
    assign div_zero  = (op2 == '0);
    assign overflow  = is_signed & (op1 == {1'b1, {(XLEN-1){1'b0}}}) & (op2 == '1);

`ifdef EX_DIV_EARLY_OUT_EN
    assign early_out = ~div_zero & (mag_a < mag_b);
`else
    assign early_out = 1'b0;
`endif

    assign special = div_zero | overflow | early_out;

    // Results that need no iteration. For early-out the quotient is zero and
    // the sign-corrected remainder magnitude is simply the original dividend.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        special_res = '0;
        if (div_zero) begin
            special_res = funct[1] ? op1 : '1;
        end else if (overflow) begin
            special_res = funct[1] ? '0 : op1;
        end else if (early_out) begin
            special_res = funct[1] ? op1 : '0;
        end
    end

    // ------------------------------------------------------------------
    // One restoring-division step
    // ------------------------------------------------------------------
    logic [XLEN:0]   shift_rem;
    logic [XLEN+1:0] trial;
    logic [XLEN-1:0] rem_nxt;
    logic [XLEN-1:0] quot_nxt;
    logic            last_iter;
    logic [XLEN-1:0] quot_fin;
    logic [XLEN-1:0] rem_fin;
    logic [XLEN-1:0] fin_res;

    // Partial remainder stays below the divisor, so the shifted value fits in
    // XLEN+1 bits; the extra top bit of trial acts as the borrow flag.
    assign shift_rem = {rem_q, quot_q[XLEN-1]};
    assign trial     = {1'b0, shift_rem} - {2'b00, dvsr_q};

    always_comb begin
        rem_nxt  = shift_rem[XLEN-1:0];
        quot_nxt = {quot_q[XLEN-2:0], 1'b0};
        if (!trial[XLEN+1]) begin
            rem_nxt  = trial[XLEN-1:0];
            quot_nxt = {quot_q[XLEN-2:0], 1'b1};
        end
    end

    assign last_iter = (cnt_q == CNT_W'(XLEN-1));
    assign quot_fin  = neg_q_q ? -quot_nxt : quot_nxt;
    assign rem_fin   = neg_r_q ? -rem_nxt  : rem_nxt;
    assign fin_res   = sel_rem_q ? rem_fin : quot_fin;

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= S_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = special ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (flush) begin
                    state_nxt = S_IDLE;
                end else if (last_iter) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sel_rem_q    <= 1'b0;
            neg_q_q      <= 1'b0;
            neg_r_q      <= 1'b0;
            rd_wen_cap_q <= 1'b0;
            rd_wen_q     <= 1'b0;
            rd_addr_o    <= '0;
            result       <= '0;
            rem_q        <= '0;
            quot_q       <= '0;
            dvsr_q       <= '0;
            cnt_q        <= '0;
        end else begin
            // The strobe is only ever raised on the edge that enters DONE.
            rd_wen_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        sel_rem_q    <= funct[1];
                        neg_q_q      <= is_signed & (op1[XLEN-1] ^ op2[XLEN-1]);
                        neg_r_q      <= is_signed & op1[XLEN-1];
                        rd_wen_cap_q <= rd_wen;
                        rd_addr_o    <= rd_addr;
                        rem_q        <= '0;
                        quot_q       <= mag_a;
                        dvsr_q       <= mag_b;
                        cnt_q        <= '0;
                        if (special) begin
                            result   <= special_res;
                            rd_wen_q <= rd_wen;
                        end
                    end
                end
                S_CALC: begin
                    if (!flush) begin
                        rem_q  <= rem_nxt;
                        quot_q <= quot_nxt;
                        cnt_q  <= cnt_q + CNT_W'(1);
                        // Final step: sign-correct straight into result so the
                        // strobe and the value appear together in DONE.
                        if (last_iter) begin
                            result   <= fin_res;
                            rd_wen_q <= rd_wen_cap_q;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // A flush arriving while DONE is presented must still kill the write, so
    // the registered strobe is gated by flush on its way out.
    assign rd_wen_o  = rd_wen_q & ~flush;
    assign busy      = (state != S_IDLE);
    assign stall_req = accept | (state == S_CALC);

endmodule

// File: tb/tb_ex_div.sv
// ----------------------------------------------------------------------------
// tb_ex_div -- self-checking bench for ex_div.
//
// A behavioural model states what each operation must return (plain RISC-V
// division semantics on integers) and when its writeback strobe must appear.
// A single compare process checks busy, stall_req, rd_wen_o, result and
// rd_addr_o against that model on every falling edge. Directed vectors also
// pin the model to hand-computed values.
// ----------------------------------------------------------------------------
module tb_ex_div;

    localparam int XLEN = 32;

    logic        sys_clk;
    logic        sys_rst_n;
    logic        start;
    logic [1:0]  funct;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  rd_addr;
    logic        rd_wen;
    logic        flush;
    logic        busy;
    logic        stall_req;
    logic [31:0] result;
    logic [4:0]  rd_addr_o;
    logic        rd_wen_o;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Model of the single outstanding operation
    bit          p_valid;
    int          p_k0;        // cycle index of the first busy cycle
    int          p_busy_end;  // last busy cycle
    int          p_pulse;     // cycle with the writeback (-1: none)
    bit          p_wen;
    logic [31:0] p_res;
    logic [4:0]  p_addr;
    logic [31:0] last_res;    // value result must hold

    localparam logic [1:0] F_DIV  = 2'b00;
    localparam logic [1:0] F_DIVU = 2'b01;
    localparam logic [1:0] F_REM  = 2'b10;
    localparam logic [1:0] F_REMU = 2'b11;

    ex_div #(.XLEN(XLEN)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .start     (start),
        .funct     (funct),
        .op1       (op1),
        .op2       (op2),
        .rd_addr   (rd_addr),
        .rd_wen    (rd_wen),
        .flush     (flush),
        .busy      (busy),
        .stall_req (stall_req),
        .result    (result),
        .rd_addr_o (rd_addr_o),
        .rd_wen_o  (rd_wen_o)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    // RISC-V M-extension semantics
    function automatic logic [31:0] ref_div(input logic [1:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
        int sa;
        int sb;
        sa = a;
        sb = b;
        if (b == 32'd0) return f[1] ? a : 32'hFFFF_FFFF;
        if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f[1] ? 32'd0 : a;
        case (f)
            F_DIV:   return sa / sb;
            F_DIVU:  return a / b;
            F_REM:   return sa % sb;
            default: return a % b;
        endcase
    endfunction

    // Start edge to strobe, in cycles
    function automatic int ref_lat(input logic [1:0] f, input logic [31:0] a,
                                   input logic [31:0] b);
        if (b == 32'd0) return 1;
        if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef EX_DIV_EARLY_OUT_EN
        begin
            logic [31:0] ma;
            logic [31:0] mb;
            ma = (!f[0] && a[31]) ? -a : a;
            mb = (!f[0] && b[31]) ? -b : b;
            if (ma < mb) return 1;
        end
`endif
        return XLEN + 1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Per-cycle comparison against the model
    bit cmp_busy;
    bit cmp_pulse;
    always @(negedge sys_clk) begin
        if (!sys_rst_n) begin
            last_res = 32'd0;
        end else begin
            cmp_busy  = p_valid && cyc >= p_k0 && cyc <= p_busy_end;
            cmp_pulse = p_valid && cyc == p_pulse;
            if (cmp_pulse) last_res = p_res;
            check($sformatf("busy@%0d", cyc), {31'd0, busy}, {31'd0, cmp_busy});
            check($sformatf("stall_req@%0d", cyc), {31'd0, stall_req},
                  {31'd0, (cmp_busy && !cmp_pulse) || (!cmp_busy && start && !flush)});
            check($sformatf("rd_wen_o@%0d", cyc), {31'd0, rd_wen_o},
                  {31'd0, cmp_pulse && p_wen && !flush});
            check($sformatf("result@%0d", cyc), result, last_res);
            if (cmp_pulse && p_wen)
                check($sformatf("rd_addr_o@%0d", cyc), {27'd0, rd_addr_o}, {27'd0, p_addr});
        end
    end

    // Drive one start cycle and record the expected behaviour.
    // Returns #1 after the accepting edge.
    task automatic launch(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] addr, input bit wen);
        int lat;
        @(posedge sys_clk); #1;
        start   = 1'b1;
        funct   = f;
        op1     = a;
        op2     = b;
        rd_addr = addr;
        rd_wen  = wen;
        lat        = ref_lat(f, a, b);
        p_k0       = cyc + 1;
        p_pulse    = p_k0 + lat - 1;
        p_busy_end = p_pulse;
        p_wen      = wen;
        p_res      = ref_div(f, a, b);
        p_addr     = addr;
        p_valid    = 1'b1;
        @(posedge sys_clk); #1;
        start = 1'b0;
    endtask

    // Full directed vector; poke>0 raises a bogus start that many cycles
    // into CALC, which must be ignored.
    task automatic run_vec(input string name, input logic [1:0] f, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] addr, input bit wen,
                           input logic [31:0] lit, input int poke);
        check({name, " model"}, ref_div(f, a, b), lit);
        launch(f, a, b, addr, wen);
        if (poke > 0) begin
            repeat (poke) begin @(posedge sys_clk); #1; end
            start = 1'b1; funct = F_REMU; op1 = 32'h999; op2 = 32'd1; rd_addr = 5'd31; rd_wen = 1'b1;
            @(posedge sys_clk); #1;
            start = 1'b0;
        end
        while (cyc <= p_pulse) begin @(posedge sys_clk); #1; end
        check({name, " result"}, result, lit);
        check({name, " idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        sys_rst_n = 1'b0; start = 1'b0; flush = 1'b0; funct = 2'b00;
        op1 = '0; op2 = '0; rd_addr = '0; rd_wen = 1'b0;
        p_valid = 1'b0; p_k0 = 0; p_busy_end = -1; p_pulse = -1;
        p_wen = 1'b0; p_res = '0; p_addr = '0; last_res = '0;

        repeat (2) @(posedge sys_clk);
        #1;
        check("reset busy",      {31'd0, busy},      32'd0);
        check("reset stall_req", {31'd0, stall_req}, 32'd0);
        check("reset rd_wen_o",  {31'd0, rd_wen_o},  32'd0);
        check("reset result",    result,             32'd0);
        check("reset rd_addr_o", {27'd0, rd_addr_o}, 32'd0);
        sys_rst_n = 1'b1;

        run_vec("divu 100/7",      F_DIVU, 32'd100,        32'd7,          5'd5,  1'b1, 32'd14,        5);
        run_vec("rem -100/7",      F_REM,  32'hFFFF_FF9C,  32'd7,          5'd6,  1'b1, 32'hFFFF_FFFE, 0);
        run_vec("div -100/7",      F_DIV,  32'hFFFF_FF9C,  32'd7,          5'd7,  1'b1, 32'hFFFF_FFF2, 0);
        run_vec("divu by zero",    F_DIVU, 32'h1234,       32'd0,          5'd8,  1'b1, 32'hFFFF_FFFF, 0);
        run_vec("remu by zero",    F_REMU, 32'h1234,       32'd0,          5'd9,  1'b1, 32'h1234,      0);
        run_vec("div overflow",    F_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  5'd10, 1'b1, 32'h8000_0000, 0);
        run_vec("rem overflow",    F_REM,  32'h8000_0000,  32'hFFFF_FFFF,  5'd11, 1'b1, 32'd0,         0);
        run_vec("divu 3/10",       F_DIVU, 32'd3,          32'd10,         5'd12, 1'b1, 32'd0,         0);
        run_vec("remu 3/10",       F_REMU, 32'd3,          32'd10,         5'd13, 1'b1, 32'd3,         0);
        run_vec("rem -3/10",       F_REM,  32'hFFFF_FFFD,  32'd10,         5'd14, 1'b1, 32'hFFFF_FFFD, 0);
        run_vec("div 0/0 no wen",  F_DIV,  32'd0,          32'd0,          5'd0,  1'b0, 32'hFFFF_FFFF, 0);
        run_vec("divu 20/4 no wen",F_DIVU, 32'd20,         32'd4,          5'd0,  1'b0, 32'd5,         0);
        run_vec("div 7/-2",        F_DIV,  32'd7,          32'hFFFF_FFFE,  5'd15, 1'b1, 32'hFFFF_FFFD, 0);
        run_vec("rem 7/-2",        F_REM,  32'd7,          32'hFFFF_FFFE,  5'd16, 1'b1, 32'd1,         0);
        run_vec("rem -7/2",        F_REM,  32'hFFFF_FFF9,  32'd2,          5'd17, 1'b1, 32'hFFFF_FFFF, 0);
        run_vec("divu max/1",      F_DIVU, 32'hFFFF_FFFF,  32'd1,          5'd18, 1'b1, 32'hFFFF_FFFF, 0);
        run_vec("remu max/16",     F_REMU, 32'hFFFF_FFFF,  32'h10,         5'd19, 1'b1, 32'hF,         0);
        run_vec("div min/2",       F_DIV,  32'h8000_0000,  32'd2,          5'd20, 1'b1, 32'hC000_0000, 0);

        // Flush at CALC cycle 10: no write, idle on the next cycle
        launch(F_DIVU, 32'd50, 32'd3, 5'd21, 1'b1);
        repeat (9) begin @(posedge sys_clk); #1; end
        flush      = 1'b1;
        p_busy_end = cyc;
        p_pulse    = -1;
        @(posedge sys_clk); #1;
        flush = 1'b0;
        check("flush busy after", {31'd0, busy}, 32'd0);
        run_vec("divu 9/3 after flush", F_DIVU, 32'd9, 32'd3, 5'd22, 1'b1, 32'd3, 0);

        // Reset at CALC cycle 20, together with flush: outputs clear at once
        launch(F_DIVU, 32'd1000, 32'd7, 5'd23, 1'b1);
        repeat (19) begin @(posedge sys_clk); #1; end
        #2;
        flush     = 1'b1;
        sys_rst_n = 1'b0;
        p_valid   = 1'b0;
        p_pulse   = -1;
        #1;
        check("midreset busy",      {31'd0, busy},      32'd0);
        check("midreset stall_req", {31'd0, stall_req}, 32'd0);
        check("midreset rd_wen_o",  {31'd0, rd_wen_o},  32'd0);
        check("midreset result",    result,             32'd0);
        check("midreset rd_addr_o", {27'd0, rd_addr_o}, 32'd0);
        @(posedge sys_clk); #1;
        flush = 1'b0;
        @(posedge sys_clk); #1;
        sys_rst_n = 1'b1;
        run_vec("div 7/-2 after reset", F_DIV, 32'd7, 32'hFFFF_FFFE, 5'd24, 1'b1, 32'hFFFF_FFFD, 0);

        repeat (3) @(posedge sys_clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
